// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: mode encodings and
// small decode helpers used by the datapath and the frame counter.
package usr_pkg;

    typedef enum logic [1:0] {
        HOLD = 2'b00,
        SHL  = 2'b01,
        SHR  = 2'b10,
        LOAD = 2'b11
    } mode_e;

    localparam int DEFAULT_WIDTH = 8;

    function automatic logic is_shift(input mode_e mode);
        return (mode == SHL) || (mode == SHR);
    endfunction

    function automatic logic is_load(input mode_e mode);
        return (mode == LOAD);
    endfunction

endpackage : usr_pkg

// File: rtl/shift_frame_counter.sv
// Counts shifts after a parallel load; busy spans the frame, done pulses for
// one cycle after the Nth shift. A new load restarts the frame silently.
module shift_frame_counter
    import usr_pkg::*;
#(
    parameter  int N  = DEFAULT_WIDTH,
    localparam int CW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          shift,
    output logic [CW-1:0] cnt,
    output logic          busy,
    output logic          done
);

    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          busy_q;
    logic          busy_d;
    logic          done_q;
    logic          done_d;

    // Next-state: load wins over shift; shifts outside a frame leave the count at zero.
    always_comb begin
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        if (load) begin
            cnt_d  = {CW{1'b0}};
            busy_d = 1'b1;
        end else if (shift && busy_q) begin
            if (cnt_q == LAST) begin
                cnt_d  = {CW{1'b0}};
                busy_d = 1'b0;
                done_d = 1'b1;
            end else begin
                cnt_d  = cnt_q + CW'(1);
            end
        end else begin
            cnt_d  = cnt_q;
            busy_d = busy_q;
        end
    end

    // Frame state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= {CW{1'b0}};
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign cnt  = cnt_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule : shift_frame_counter

// File: rtl/universal_shift_register.sv
// N-bit universal shift register (hold / shift left / shift right / load)
// with a frame counter tracking shifts completed since the last load.
module universal_shift_register
    import usr_pkg::*;
#(
    parameter  int N  = DEFAULT_WIDTH,
    localparam int CW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic [1:0]    ctrl,
    input  logic          si_r,
    input  logic          si_l,
    input  logic [N-1:0]  d,
    output logic [N-1:0]  q,
    output logic          so_r,
    output logic          so_l,
    output logic [CW-1:0] cnt,
    output logic          busy,
    output logic          done
);

    mode_e        mode_s;
    logic         load_s;
    logic         shift_s;
    logic [N-1:0] data_q;
    logic [N-1:0] data_d;

    assign mode_s  = mode_e'(ctrl);
    assign load_s  = en && is_load(mode_s);
    assign shift_s = en && is_shift(mode_s);

    // Datapath next-state; clock enable low freezes the register for any mode.
    always_comb begin
        data_d = data_q;
        if (en) begin
            case (mode_s)
                SHL:     data_d = {data_q[N-2:0], si_l};
                SHR:     data_d = {si_r, data_q[N-1:1]};
                LOAD:    data_d = d;
                HOLD:    data_d = data_q;
                default: data_d = data_q;
            endcase
        end else begin
            data_d = data_q;
        end
    end

    // Datapath state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= {N{1'b0}};
        end else begin
            data_q <= data_d;
        end
    end

    shift_frame_counter #(
        .N (N)
    ) u_frame (
        .clk   (clk),
        .reset (reset),
        .load  (load_s),
        .shift (shift_s),
        .cnt   (cnt),
        .busy  (busy),
        .done  (done)
    );

    assign q    = data_q;
    assign so_r = data_q[0];
    assign so_l = data_q[N-1];

endmodule : universal_shift_register

// File: tb/tb_universal_shift_register.sv
// Self-checking bench for universal_shift_register (N=8): a behavioural model
// queues the expected outputs per cycle; each scenario pops and compares.
module tb_universal_shift_register;

    localparam int N  = 8;
    localparam int CW = 4;

    logic          clk;
    logic          reset;
    logic          en;
    logic [1:0]    ctrl;
    logic          si_r;
    logic          si_l;
    logic [N-1:0]  d;
    logic [N-1:0]  q;
    logic          so_r;
    logic          so_l;
    logic [CW-1:0] cnt;
    logic          busy;
    logic          done;

    int n_checks;
    int n_err;

    logic [N-1:0]  m_q;
    logic [CW-1:0] m_cnt;
    logic          m_busy;
    logic          m_done;
    logic [15:0]   sb[$];

    universal_shift_register #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .ctrl  (ctrl),
        .si_r  (si_r),
        .si_l  (si_l),
        .d     (d),
        .q     (q),
        .so_r  (so_r),
        .so_l  (so_l),
        .cnt   (cnt),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle, advance the model, queue the expected outputs.
    task automatic drive(input logic r, input logic e, input logic [1:0] c,
                         input logic sir, input logic sil, input logic [7:0] dd);
        reset = r; en = e; ctrl = c; si_r = sir; si_l = sil; d = dd;
        m_done = 1'b0;
        if (r) begin
            m_q = 8'h00; m_cnt = 4'd0; m_busy = 1'b0;
        end else if (e) begin
            if (c == 2'b11) begin
                m_q = dd; m_cnt = 4'd0; m_busy = 1'b1;
            end else if (c == 2'b01 || c == 2'b10) begin
                m_q = (c == 2'b01) ? {m_q[6:0], sil} : {sir, m_q[7:1]};
                if (m_busy) begin
                    if (m_cnt == 4'd7) begin
                        m_cnt = 4'd0; m_busy = 1'b0; m_done = 1'b1;
                    end else begin
                        m_cnt = m_cnt + 4'd1;
                    end
                end
            end
        end
        sb.push_back({m_q, m_cnt, m_busy, m_done, m_q[0], m_q[7]});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [15:0] exp_v;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
            exp_v = sb.pop_front();
            n_checks++;
            if ({q, cnt, busy, done, so_r, so_l} !== exp_v) begin
                n_err++;
                $display("FAIL reset_sb cyc%0d got=%h exp=%h", i, {q, cnt, busy, done, so_r, so_l}, exp_v);
            end
        end
        n_checks++;
        if ({q, cnt, busy, done} !== 14'h0000) begin
            n_err++;
            $display("FAIL reset_state got q=%h cnt=%0d busy=%b done=%b exp all zero", q, cnt, busy, done);
        end
    endtask

    task automatic test_shift_right();
        logic [15:0] exp_v;
        logic [7:0]  seq;
        seq = 8'b10100101;
        drive(1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 8'hA5);
        exp_v = sb.pop_front();
        n_checks++;
        if ({q, cnt, busy, done, so_r, so_l} !== exp_v) begin
            n_err++;
            $display("FAIL shr_load got=%h exp=%h", {q, cnt, busy, done, so_r, so_l}, exp_v);
        end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (so_r !== seq[7-i]) begin
                n_err++;
                $display("FAIL shr_so_r bit%0d got=%b exp=%b", i, so_r, seq[7-i]);
            end
            drive(1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 8'h00);
            exp_v = sb.pop_front();
            n_checks++;
            if ({q, cnt, busy, done, so_r, so_l} !== exp_v) begin
                n_err++;
                $display("FAIL shr_sb shift%0d got=%h exp=%h", i, {q, cnt, busy, done, so_r, so_l}, exp_v);
            end
            n_checks++;
            if (done !== (i == 7)) begin
                n_err++;
                $display("FAIL shr_done shift%0d got=%b exp=%b", i, done, (i == 7));
            end
        end
        n_checks++;
        if (q !== 8'h00 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL shr_final got q=%h busy=%b exp q=00 busy=0", q, busy);
        end
        drive(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 8'h00);
        exp_v = sb.pop_front();
        n_checks++;
        if ({q, cnt, busy, done, so_r, so_l} !== exp_v || done !== 1'b0) begin
            n_err++;
            $display("FAIL shr_hold_after got=%h exp=%h", {q, cnt, busy, done, so_r, so_l}, exp_v);
        end
    endtask

    task automatic test_shift_left();
        logic [15:0] exp_v;
        logic [23:0] steps;
        steps = {8'h03, 8'h07, 8'h0F};
        drive(1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 8'h81);
        void'(sb.pop_front());
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 2'b01, 1'b0, 1'b1, 8'h00);
            exp_v = sb.pop_front();
            n_checks++;
            if ({q, cnt, busy, done, so_r, so_l} !== exp_v || q !== steps[23-8*i -: 8]) begin
                n_err++;
                $display("FAIL shl_step%0d got q=%h vec=%h exp q=%h vec=%h", i, q,
                         {q, cnt, busy, done, so_r, so_l}, steps[23-8*i -: 8], exp_v);
            end
        end
        n_checks++;
        if (cnt !== 4'd3 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL shl_count got cnt=%0d busy=%b exp cnt=3 busy=1", cnt, busy);
        end
    endtask

    task automatic test_pause();
        logic [15:0] exp_v;
        logic [7:0]  held;
        drive(1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 8'h3C);
        void'(sb.pop_front());
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 2'b10, 1'($urandom), 1'b0, 8'h00);
            void'(sb.pop_front());
        end
        held = q;
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 2'b11, 1'b1, 1'b1, 8'($urandom));
            exp_v = sb.pop_front();
            n_checks++;
            if ({q, cnt, busy, done, so_r, so_l} !== exp_v || q !== held || cnt !== 4'd3 || done !== 1'b0) begin
                n_err++;
                $display("FAIL pause_hold cyc%0d got q=%h cnt=%0d done=%b exp q=%h cnt=3 done=0", i, q, cnt, done, held);
            end
        end
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, (i % 2 == 0) ? 2'b01 : 2'b10, 1'($urandom), 1'($urandom), 8'h00);
            exp_v = sb.pop_front();
            n_checks++;
            if ({q, cnt, busy, done, so_r, so_l} !== exp_v || done !== (i == 4)) begin
                n_err++;
                $display("FAIL pause_resume shift%0d got=%h done=%b exp=%h", i, {q, cnt, busy, done, so_r, so_l}, done, exp_v);
            end
        end
    endtask

    task automatic test_reload();
        logic [15:0] exp_v;
        int          pulses;
        drive(1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 8'hF0);
        void'(sb.pop_front());
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 8'h00);
            void'(sb.pop_front());
        end
        drive(1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 8'hFF);
        exp_v = sb.pop_front();
        n_checks++;
        if ({q, cnt, busy, done, so_r, so_l} !== exp_v || cnt !== 4'd0 || busy !== 1'b1 || done !== 1'b0) begin
            n_err++;
            $display("FAIL reload_restart got cnt=%0d busy=%b done=%b exp cnt=0 busy=1 done=0", cnt, busy, done);
        end
        pulses = 0;
        for (int i = 0; i < 9; i++) begin
            drive(1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 8'h00);
            exp_v = sb.pop_front();
            pulses += int'(done);
            n_checks++;
            if ({q, cnt, busy, done, so_r, so_l} !== exp_v) begin
                n_err++;
                $display("FAIL reload_sb shift%0d got=%h exp=%h", i, {q, cnt, busy, done, so_r, so_l}, exp_v);
            end
        end
        n_checks++;
        if (pulses != 1) begin
            n_err++;
            $display("FAIL reload_pulses got=%0d exp=1", pulses);
        end
    endtask

    task automatic test_reset_midframe();
        logic [15:0] exp_v;
        drive(1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 8'h5A);
        void'(sb.pop_front());
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 2'b01, 1'b1, 1'b1, 8'h00);
            void'(sb.pop_front());
        end
        drive(1'b1, 1'b1, 2'b01, 1'b1, 1'b1, 8'h00);
        void'(sb.pop_front());
        n_checks++;
        if ({q, cnt, busy, done, so_r, so_l} !== 16'h0000) begin
            n_err++;
            $display("FAIL midreset_state got=%h exp=0000", {q, cnt, busy, done, so_r, so_l});
        end
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b1, (i % 3 == 0) ? 2'b10 : 2'b01, 1'($urandom), 1'($urandom), 8'h00);
            exp_v = sb.pop_front();
            n_checks++;
            if ({q, cnt, busy, done, so_r, so_l} !== exp_v || done !== 1'b0 || cnt !== 4'd0) begin
                n_err++;
                $display("FAIL midreset_noframe shift%0d got=%h done=%b exp=%h", i, {q, cnt, busy, done, so_r, so_l}, done, exp_v);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] exp_v;
        logic [1:0]  c;
        for (int i = 0; i < 400; i++) begin
            c = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) != 0), c,
                  1'($urandom), 1'($urandom), 8'($urandom));
            exp_v = sb.pop_front();
            n_checks++;
            if ({q, cnt, busy, done, so_r, so_l} !== exp_v) begin
                n_err++;
                $display("FAIL random_sb cyc%0d got=%h exp=%h", i, {q, cnt, busy, done, so_r, so_l}, exp_v);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        reset = 1'b1; en = 1'b0; ctrl = 2'b00; si_r = 1'b0; si_l = 1'b0; d = 8'h00;
        m_q = 8'h00; m_cnt = 4'd0; m_busy = 1'b0; m_done = 1'b0;
        #1;
        test_reset();
        test_shift_right();
        test_shift_left();
        test_pause();
        test_reload();
        test_reset_midframe();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_universal_shift_register
